// File: rtl/uart_boot_loader.sv
// UART program loader: receives an 8N1 image (count, words, optional checksum) and writes it into
// instruction memory while holding the core in reset. Define BOOT_CHECKSUM_EN to require a trailing XOR byte.
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [32:0]   MAX_WORDS = 33'd1 << ADDR_WIDTH;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    LD_COUNT,
    LD_DATA,
`ifdef BOOT_CHECKSUM_EN
    LD_CHECK,
`endif
    LD_DONE,
    LD_ERROR
  } ld_state_t;

  // The state entered once the last word (or an empty count) has been consumed.
`ifdef BOOT_CHECKSUM_EN
  localparam ld_state_t LD_FINISH = LD_CHECK;
`else
  localparam ld_state_t LD_FINISH = LD_DONE;
`endif

  logic rx_meta_q, rx_meta_d;
  logic rx_sync_q, rx_sync_d;
  logic rx_prev_q, rx_prev_d;

  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid;
  logic            frame_err;

  ld_state_t             ld_state_q, ld_state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]           asm_q, asm_d;
  logic [31:0]           count_q, count_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic                  last_word;
  logic                  imem_we_q, imem_we_d;
  logic [31:0]           imem_addr_q, imem_addr_d;
  logic [31:0]           imem_data_q, imem_data_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  // Synchronizer plus one extra stage so a falling edge is seen the first cycle rx_sync_q goes low.
  always_comb begin
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          cnt_d      = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d      = '0;
          bit_idx_d  = 3'd0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d      = '0;
          rx_state_d = RX_IDLE;
          byte_valid = rx_sync_q;
          frame_err  = !rx_sync_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign last_word = (32'(word_idx_q) == count_q - 32'd1);

  always_comb begin
    ld_state_d  = ld_state_q;
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    count_d     = count_q;
    word_idx_d  = word_idx_q;
    imem_we_d   = 1'b0;
    imem_addr_d = imem_addr_q;
    imem_data_d = imem_data_q;
    cpu_reset_d = cpu_reset_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
`ifdef BOOT_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (ld_state_q)
      LD_COUNT: begin
        if (frame_err) begin
          ld_state_d = LD_ERROR;
          error_d    = 1'b1;
          busy_d     = 1'b0;
        end else if (byte_valid) begin
          busy_d     = 1'b1;
          asm_d      = {shift_q, asm_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            count_d = asm_d;
            if ({1'b0, asm_d} > MAX_WORDS) begin
              ld_state_d = LD_ERROR;
              error_d    = 1'b1;
              busy_d     = 1'b0;
            end else if (asm_d == 32'd0) begin
              ld_state_d = LD_FINISH;
            end else begin
              ld_state_d = LD_DATA;
            end
          end
        end
      end
      LD_DATA: begin
        if (frame_err) begin
          ld_state_d = LD_ERROR;
          error_d    = 1'b1;
          busy_d     = 1'b0;
        end else if (byte_valid) begin
          asm_d      = {shift_q, asm_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
          csum_d     = csum_q ^ shift_q;
`endif
          if (byte_cnt_q == 2'd3) begin
            imem_we_d   = 1'b1;
            imem_addr_d = 32'(word_idx_q) << 2;
            imem_data_d = asm_d;
            word_idx_d  = word_idx_q + ADDR_WIDTH'(1);
            if (last_word) ld_state_d = LD_FINISH;
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      LD_CHECK: begin
        if (frame_err || (byte_valid && shift_q != csum_q)) begin
          ld_state_d = LD_ERROR;
          error_d    = 1'b1;
          busy_d     = 1'b0;
        end else if (byte_valid) begin
          ld_state_d = LD_DONE;
        end
      end
`endif
      // Completion flags are raised one cycle after entering DONE, i.e. after the final write.
      LD_DONE: begin
        busy_d      = 1'b0;
        done_d      = 1'b1;
        cpu_reset_d = 1'b0;
      end
      LD_ERROR: begin
        busy_d = 1'b0;
      end
      default: ld_state_d = LD_ERROR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      ld_state_q  <= LD_COUNT;
      byte_cnt_q  <= 2'd0;
      asm_q       <= 32'd0;
      count_q     <= 32'd0;
      word_idx_q  <= '0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= 32'd0;
      imem_data_q <= 32'd0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_q      <= 8'd0;
`endif
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      ld_state_q  <= ld_state_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      imem_we_q   <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      imem_data_q <= imem_data_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign imem_we   = imem_we_q;
  assign imem_addr = imem_addr_q;
  assign imem_data = imem_data_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: normal, empty, framing, range, glitch and (with BOOT_CHECKSUM_EN) checksum loads.
module tb_uart_boot_loader;

  localparam int CPB = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  int          wr_total = 0;
  logic        done_at_we = 1'bx;
  logic        done_after = 1'bx;
  logic        rst_after  = 1'bx;
  logic        pending_after = 1'b0;
  int          base;

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(10)) dut (
    .clock(clock), .reset(reset), .rx(rx),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  // Write monitor: logs every strobe plus the done/cpu_reset state during and one cycle after it.
  always @(negedge clock) begin
    if (pending_after) begin
      done_after    = done;
      rst_after     = cpu_reset;
      pending_after = 1'b0;
    end
    if (imem_we) begin
      if (wr_total < 64) begin
        wr_addr[wr_total] = imem_addr;
        wr_data[wr_total] = imem_data;
      end
      wr_total      = wr_total + 1;
      done_at_we    = done;
      pending_after = 1'b1;
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: observed timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: observed 0x%08h, required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One 8N1 frame, starting immediately so consecutive calls are back-to-back.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    idleCycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idleCycles(CPB);
    end
    rx = stop_bit;
    idleCycles(CPB);
    rx = 1'b1;
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int i = 0; i < 4; i++) applyStimulus(w[8*i +: 8], 1'b1);
  endtask

  task automatic doReset();
    rx    = 1'b1;
    reset = 1'b1;
    idleCycles(4);
    reset = 1'b0;
    idleCycles(4);
    base = wr_total;
  endtask

  initial begin
    #1;
    idleCycles(3);
    checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("rst_imem_we",   32'(imem_we),   32'd0);
    checkOutput("rst_imem_addr", imem_addr,      32'd0);
    checkOutput("rst_imem_data", imem_data,      32'd0);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    checkOutput("rst_done",      32'(done),      32'd0);
    checkOutput("rst_error",     32'(error),     32'd0);

    $display("[TB] normal load, N=2");
    doReset();
    applyStimulus(8'h02, 1'b1);
    checkOutput("norm_busy_first", 32'(busy), 32'd1);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h00, 1'b1);
    sendWord(32'h0000_0013);
    sendWord(32'h0010_0093);
`ifdef BOOT_CHECKSUM_EN
    applyStimulus(8'h90, 1'b1);
`endif
    idleCycles(20);
    checkOutput("norm_writes", 32'(wr_total - base), 32'd2);
    checkOutput("norm_addr0",  wr_addr[base],     32'h0);
    checkOutput("norm_data0",  wr_data[base],     32'h0000_0013);
    checkOutput("norm_addr1",  wr_addr[base + 1], 32'h4);
    checkOutput("norm_data1",  wr_data[base + 1], 32'h0010_0093);
`ifndef BOOT_CHECKSUM_EN
    checkOutput("norm_done_at_we",  32'(done_at_we), 32'd0);
    checkOutput("norm_done_after",  32'(done_after), 32'd1);
    checkOutput("norm_cpurst_after", 32'(rst_after), 32'd0);
`endif
    checkOutput("norm_done",      32'(done),      32'd1);
    checkOutput("norm_cpu_reset", 32'(cpu_reset), 32'd0);
    checkOutput("norm_busy",      32'(busy),      32'd0);
    checkOutput("norm_error",     32'(error),     32'd0);

    $display("[TB] empty image, N=0");
    doReset();
    sendWord(32'd0);
`ifdef BOOT_CHECKSUM_EN
    applyStimulus(8'h00, 1'b1);
`endif
    idleCycles(20);
    checkOutput("empty_writes",    32'(wr_total - base), 32'd0);
    checkOutput("empty_done",      32'(done),      32'd1);
    checkOutput("empty_cpu_reset", 32'(cpu_reset), 32'd0);
    checkOutput("empty_error",     32'(error),     32'd0);

    $display("[TB] framing error on count byte 2");
    doReset();
    applyStimulus(8'h05, 1'b1);
    applyStimulus(8'h00, 1'b0);
    checkOutput("frame_error",     32'(error),     32'd1);
    checkOutput("frame_busy",      32'(busy),      32'd0);
    checkOutput("frame_cpu_reset", 32'(cpu_reset), 32'd1);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h00, 1'b1);
    sendWord(32'h0000_0013);
    idleCycles(20);
    checkOutput("frame_writes",    32'(wr_total - base), 32'd0);
    checkOutput("frame_error_kept", 32'(error), 32'd1);
    checkOutput("frame_done",      32'(done),  32'd0);

    $display("[TB] range fault and boundary");
    doReset();
    sendWord(32'h0000_0401);
    idleCycles(4);
    checkOutput("range_error",  32'(error), 32'd1);
    checkOutput("range_busy",   32'(busy),  32'd0);
    checkOutput("range_writes", 32'(wr_total - base), 32'd0);
    doReset();
    sendWord(32'h0000_0400);
    idleCycles(4);
    checkOutput("max_error", 32'(error), 32'd0);
    checkOutput("max_busy",  32'(busy),  32'd1);
    checkOutput("max_done",  32'(done),  32'd0);
    sendWord(32'hCAFE_F00D);
    idleCycles(4);
    checkOutput("max_addr0", wr_addr[base], 32'h0);
    checkOutput("max_data0", wr_data[base], 32'hCAFE_F00D);

    $display("[TB] glitch rejection then load after mid-load reset");
    doReset();
    rx = 1'b0;
    idleCycles(5);
    rx = 1'b1;
    idleCycles(200);
    checkOutput("glitch_busy", 32'(busy), 32'd0);
    sendWord(32'd1);
    sendWord(32'h1234_5678);
`ifdef BOOT_CHECKSUM_EN
    applyStimulus(8'h08, 1'b1);
`endif
    idleCycles(20);
    checkOutput("glitch_writes", 32'(wr_total - base), 32'd1);
    checkOutput("glitch_addr0",  wr_addr[base], 32'h0);
    checkOutput("glitch_data0",  wr_data[base], 32'h1234_5678);
    checkOutput("glitch_done",   32'(done),  32'd1);
    checkOutput("glitch_error",  32'(error), 32'd0);

`ifdef BOOT_CHECKSUM_EN
    $display("[TB] checksum mismatch");
    doReset();
    sendWord(32'd1);
    sendWord(32'h1234_5678);
    applyStimulus(8'h09, 1'b1);
    idleCycles(4);
    checkOutput("csum_writes",    32'(wr_total - base), 32'd1);
    checkOutput("csum_error",     32'(error),     32'd1);
    checkOutput("csum_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("csum_done",      32'(done),      32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Serial program loader that sits directly upstream of the single-cycle RISC-V core. It holds the core in reset and receives a program image over an 8N1 UART line, then writes it word-by-word into instruction memory starting at byte address 0. It releases the core's reset once the whole image has been written. A framing, range or checksum fault latches an error and keeps the core in reset.

## Interface
Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit; even, ≥ 4.
- ADDR_WIDTH, 10: instruction memory word-address width; maximum image is 2^ADDR_WIDTH words.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- rx  in  1  UART serial input; idle high; asynchronous to clock.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  32  write byte address; always word aligned (bits [1:0] = 0).
- imem_data  out  32  write data, assembled little-endian.
- cpu_reset  out  1  drives the core's reset; high until the load completes.
- busy  out  1  high from the first received byte until done or error.
- done  out  1  sticky; image fully written.
- error  out  1  sticky; load aborted.

## Operation
- rx passes through a 2-flop synchronizer (reset value 1). All UART logic uses the synchronized signal.
- Byte receiver:
  - IDLE → START on a synchronized falling edge.
  - In START, wait CLKS_PER_BIT/2 cycles and resample. If high, treat as a glitch and return to IDLE with no byte. If low, enter DATA.
  - In DATA, sample 8 bits LSB first, one every CLKS_PER_BIT cycles.
  - STOP is sampled CLKS_PER_BIT cycles after the last data bit. A stop bit of 1 produces a 1-cycle internal byte_valid. A stop bit of 0 is a framing error → loader ERROR.
- Loader FSM states: COUNT, DATA, CHECK (macro only), DONE, ERROR.
- COUNT:
  - Collect 4 bytes, little-endian, into word count N (32 bits).
  - N > 2^ADDR_WIDTH → ERROR.
  - N = 0 → DONE (CHECK when the macro is set).
  - Otherwise → DATA.
- DATA:
  - Assemble 4 bytes little-endian into imem_data.
  - On the 4th byte, pulse imem_we with imem_addr = 4·i, where i is the word index from 0.
  - After word N−1 → DONE (or CHECK).
- DONE and ERROR are terminal until reset. Bytes received in these states are ignored.
- Reset values:
  - cpu_reset = 1.
  - imem_we = 0, imem_addr = 0, imem_data = 0.
  - busy = 0, done = 0, error = 0.
  - All FSMs in IDLE/COUNT.
- Reset asserted mid-load aborts immediately. The next load restarts from COUNT at address 0.

## Timing
- A synchronized falling edge reaches the byte receiver 2 cycles after the rx pin edge.
- byte_valid is asserted in the cycle the stop bit is sampled. The loader consumes it on the next edge.
- imem_we, imem_addr and imem_data are registered. They are valid together in the cycle after the byte_valid of a word's 4th byte. imem_we is high exactly 1 cycle.
- done rises and cpu_reset falls in the same cycle, 1 cycle after the final imem_we (or after the consuming edge of the last count/checksum byte when no write occurs).
- error rises 1 cycle after the faulting sample or byte. busy falls in the same cycle that done or error rises.
- Back-to-back bytes with no idle bits between stop and the next start must be accepted.

## Configuration
- BOOT_CHECKSUM_EN defined:
  - After the last data word (or after the count when N = 0), one extra byte is received in CHECK.
  - It must equal the XOR of all 4N data bytes (0x00 when N = 0).
  - Match → DONE; mismatch → ERROR, cpu_reset stays high.
  - The count bytes are excluded from the checksum.
- BOOT_CHECKSUM_EN undefined:
  - The CHECK state and XOR accumulator are absent.
  - DONE is entered directly after the last word.

## Test plan
- Normal load: CLKS_PER_BIT=16, N=2, words 0x00000013 and 0x00100093. Expect:
  - imem_we at addr 0x0 with data 0x00000013, then addr 0x4 with data 0x00100093.
  - done=1 and cpu_reset=0 one cycle after the second write.
- Empty image: N=0. Expect no imem_we; done=1 after the 4th count byte (no macro).
- Framing error: stop bit driven 0 on count byte 2. Expect error=1, busy=0, cpu_reset=1, no writes; later bytes ignored.
- Glitch rejection: rx low for 5 cycles, then high, then a valid load. Expect no spurious byte; the load completes normally.
- Range fault: N=0x00000401 with ADDR_WIDTH=10. Expect error=1 with no writes. N=0x00000400 is accepted.
- Checksum (BOOT_CHECKSUM_EN): N=1, word 0x12345678.
  - Checksum byte 0x08 → done=1.
  - Checksum byte 0x09 → error=1 after the write, cpu_reset stays 1.
